// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, scanner state encoding and small
// helpers for decoding active-low keypad row patterns.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_CLR = 4'hE;
    localparam logic [3:0] KEY_ENT = 4'hF;

    typedef enum logic [1:0] {
        SCAN     = 2'b00,
        DEBOUNCE = 2'b01,
        HELD     = 2'b10
    } scan_state_t;

    // A row pattern names a single key only when exactly one line is pulled low.
    function automatic logic one_low(input logic [3:0] rows);
        return rows inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        case (rows)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to all-ones so
// idle pulled-up lines read as inactive.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their inputs from before the edge, giving a true two-stage delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces the
// synchronised rows and emits one key_valid pulse per physical press.
module keypad_scanner_4x4
    import calc_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       is_digit,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [3:0]    rs;
    logic [DW-1:0] dwell;
    logic          tick;
    logic [1:0]    col;
    logic [3:0]    lat_rs;
    logic [3:0]    match_cnt;
    logic [3:0]    rel_cnt;
    logic [3:0]    map_code;
    scan_state_t   state;

    sync_2ff #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_in),
        .q     (rs)
    );

    assign tick    = (dwell == DW'(SCAN_DIV - 1));
    assign col_out = ~(4'b0001 << col);

    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        map_code = 4'h0;
        case ({row_index(lat_rs), col})
            4'b00_00: map_code = 4'h1;
            4'b00_01: map_code = 4'h2;
            4'b00_10: map_code = 4'h3;
            4'b00_11: map_code = KEY_ADD;
            4'b01_00: map_code = 4'h4;
            4'b01_01: map_code = 4'h5;
            4'b01_10: map_code = 4'h6;
            4'b01_11: map_code = KEY_SUB;
            4'b10_00: map_code = 4'h7;
            4'b10_01: map_code = 4'h8;
            4'b10_10: map_code = 4'h9;
            4'b10_11: map_code = KEY_MUL;
            4'b11_00: map_code = KEY_CLR;
            4'b11_01: map_code = 4'h0;
            4'b11_10: map_code = KEY_ENT;
            4'b11_11: map_code = KEY_DIV;
            default:  map_code = 4'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            dwell     <= '0;
            col       <= 2'd0;
            lat_rs    <= 4'hF;
            match_cnt <= 4'd0;
            rel_cnt   <= 4'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            is_digit  <= 1'b1;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            dwell     <= tick ? '0 : dwell + 1'b1;

            case (state)
                SCAN: begin
                    if (tick) begin
                        if (one_low(rs)) begin
                            lat_rs    <= rs;
                            match_cnt <= 4'd1;
                            state     <= DEBOUNCE;
                        end else begin
                            col <= col + 2'd1;
                        end
                    end
                end

                DEBOUNCE: begin
                    // Accept lands one cycle after the final matching sample.
                    if (match_cnt == 4'(DEBOUNCE_CNT)) begin
                        state     <= HELD;
                        key_valid <= 1'b1;
                        key_code  <= map_code;
                        is_digit  <= (map_code <= 4'd9);
                        key_held  <= 1'b1;
                        rel_cnt   <= 4'd0;
                    end else if (tick) begin
                        if (rs == lat_rs) begin
                            match_cnt <= match_cnt + 4'd1;
                        end else begin
                            state <= SCAN;
                            col   <= col + 2'd1;
                        end
                    end
                end

                HELD: begin
                    if (tick) begin
                        if (rs == 4'hF) begin
                            if (rel_cnt == 4'(DEBOUNCE_CNT - 1)) begin
                                key_held <= 1'b0;
                                rel_cnt  <= 4'd0;
                                state    <= SCAN;
                                col      <= col + 2'd1;
                            end else begin
                                rel_cnt <= rel_cnt + 4'd1;
                            end
                        end else begin
                            rel_cnt <= 4'd0;
                        end
                    end
                end

                default: state <= SCAN;
            endcase
        end
    end

endmodule
